// File: rtl/vga_pkg.sv
// vga_pkg: shared raster defaults, pattern encoding and colour constants for the VGA pattern source.
package vga_pkg;

    // Raster counters are 10 bits wide, so every total must stay below 1024.
    localparam int CNT_W = 10;

    // 640x480@60 defaults from a 100 MHz system clock.
    localparam int CLK_DIV_DEF   = 4;
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_BANDS = 2'd3
    } pattern_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam logic [3:0] LVL_ON  = 4'hF;
    localparam logic [3:0] LVL_OFF = 4'h0;

    localparam rgb_t RGB_BLACK = '{r: LVL_OFF, g: LVL_OFF, b: LVL_OFF};
    localparam rgb_t RGB_WHITE = '{r: LVL_ON,  g: LVL_ON,  b: LVL_ON};
    localparam rgb_t RGB_RED   = '{r: LVL_ON,  g: LVL_OFF, b: LVL_OFF};
    localparam rgb_t RGB_GREEN = '{r: LVL_OFF, g: LVL_ON,  b: LVL_OFF};
    localparam rgb_t RGB_BLUE  = '{r: LVL_OFF, g: LVL_OFF, b: LVL_ON};

    // Total counts per line or per frame: visible + front porch + sync + back porch.
    function automatic int span_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    // First and last counter values at which sync is asserted.
    function automatic int sync_first(input int vis, input int fp);
        return vis + fp;
    endfunction

    function automatic int sync_last(input int vis, input int fp, input int sw);
        return vis + fp + sw - 1;
    endfunction

    // Colour-bar index for an 80-pixel bar width, built from comparators rather than a divider.
    function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x);
        logic [2:0] idx;
        if      (x < 10'd80)  idx = 3'd0;
        else if (x < 10'd160) idx = 3'd1;
        else if (x < 10'd240) idx = 3'd2;
        else if (x < 10'd320) idx = 3'd3;
        else if (x < 10'd400) idx = 3'd4;
        else if (x < 10'd480) idx = 3'd5;
        else if (x < 10'd560) idx = 3'd6;
        else                  idx = 3'd7;
        return idx;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-rate divider, horizontal/vertical raster counters and sync/visible-area decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = CLK_DIV_DEF,
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             pix_tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             frame_wrap,
    output logic             active,
    output logic             h_sync_next,
    output logic             v_sync_next
);

    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_TOTAL  = span_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = span_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
    localparam int HS_FIRST = sync_first(H_VISIBLE, H_FP);
    localparam int HS_LAST  = sync_last(H_VISIBLE, H_FP, H_SYNC);
    localparam int VS_FIRST = sync_first(V_VISIBLE, V_FP);
    localparam int VS_LAST  = sync_last(V_VISIBLE, V_FP, V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic             h_last;
    logic             v_last;

    assign pix_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last     = (v_cnt == CNT_W'(V_TOTAL - 1));
    assign frame_wrap = pix_tick && h_last && v_last;

    // Divide the system clock down to one pixel tick every CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Advance the raster position once per pixel tick, wrapping line then frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Decode visible area and sync windows from the current raster position.
    always_comb begin
        active      = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
        h_sync_next = ~SYNC_POL;
        v_sync_next = ~SYNC_POL;
        if ((h_cnt >= CNT_W'(HS_FIRST)) && (h_cnt <= CNT_W'(HS_LAST))) begin
            h_sync_next = SYNC_POL;
        end
        if ((v_cnt >= CNT_W'(VS_FIRST)) && (v_cnt <= CNT_W'(VS_LAST))) begin
            v_sync_next = SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus a 4-bit-per-channel test pattern, with pattern changes held to frame boundaries.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int   CLK_DIV   = CLK_DIV_DEF,
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       sel_pattern,
    output logic             h_sync,
    output logic             v_sync,
    output logic             de,
    output logic [CNT_W-1:0] x_pixel,
    output logic [CNT_W-1:0] y_pixel,
    output logic             frame_start,
    output logic [3:0]       o_r,
    output logic [3:0]       o_g,
    output logic [3:0]       o_b
);

    logic             pix_tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             frame_wrap;
    logic             active;
    logic             h_sync_next;
    logic             v_sync_next;
    pattern_e         pattern_q;
    rgb_t             pix_colour;
    logic [2:0]       bar;

    vga_timing #(
        .CLK_DIV   (CLK_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .SYNC_POL  (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_tick    (pix_tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_wrap  (frame_wrap),
        .active      (active),
        .h_sync_next (h_sync_next),
        .v_sync_next (v_sync_next)
    );

    // Latch the requested pattern only on the frame-wrap tick so a frame never mixes patterns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= PAT_BARS;
        end else if (frame_wrap) begin
            pattern_q <= pattern_e'(sel_pattern);
        end
    end

    // Colour of the pixel at the current raster position under the active pattern.
    always_comb begin
        pix_colour = RGB_BLACK;
        bar        = bar_index(h_cnt);
        case (pattern_q)
            PAT_BARS: begin
                pix_colour.r = bar[1] ? LVL_OFF : LVL_ON;
                pix_colour.g = bar[2] ? LVL_OFF : LVL_ON;
                pix_colour.b = bar[0] ? LVL_OFF : LVL_ON;
            end
            PAT_CHECK: begin
                pix_colour = (h_cnt[5] ^ v_cnt[5]) ? RGB_WHITE : RGB_BLACK;
            end
            PAT_RAMP: begin
                pix_colour = '{r: h_cnt[9:6], g: h_cnt[9:6], b: h_cnt[9:6]};
            end
            PAT_BANDS: begin
                if (v_cnt < 10'd160) begin
                    pix_colour = RGB_RED;
                end else if (v_cnt < 10'd320) begin
                    pix_colour = RGB_GREEN;
                end else begin
                    pix_colour = RGB_BLUE;
                end
            end
            default: pix_colour = RGB_BLACK;
        endcase
    end

    // Register every video output on the pixel tick so position, sync, enable and colour stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de      <= 1'b0;
            h_sync  <= ~SYNC_POL;
            v_sync  <= ~SYNC_POL;
            x_pixel <= '0;
            y_pixel <= '0;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
        end else if (pix_tick) begin
            de      <= active;
            h_sync  <= h_sync_next;
            v_sync  <= v_sync_next;
            x_pixel <= active ? h_cnt : '0;
            y_pixel <= active ? v_cnt : '0;
            o_r     <= active ? pix_colour.r : LVL_OFF;
            o_g     <= active ? pix_colour.g : LVL_OFF;
            o_b     <= active ? pix_colour.b : LVL_OFF;
        end
    end

    // One-clock frame marker, following the frame-wrap tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench driving two differently shaped rasters from one stimulus stream.
module tb_vga_pattern_gen;

    // Wide, short raster: full 640-pixel lines, only a few lines per frame.
    localparam int W_DIV = 2;
    localparam int W_HV = 640, W_HFP = 16, W_HS = 96, W_HBP = 48;
    localparam int W_VV = 4,   W_VFP = 1,  W_VS = 1,  W_VBP = 1;
    localparam int W_HT = W_HV + W_HFP + W_HS + W_HBP;
    localparam int W_FT = W_HT * (W_VV + W_VFP + W_VS + W_VBP);

    // Narrow, tall raster: full 525-line frame, only a few pixels per line.
    localparam int T_DIV = 4;
    localparam int T_HV = 4,   T_HFP = 1,  T_HS = 1,  T_HBP = 1;
    localparam int T_VV = 480, T_VFP = 10, T_VS = 2,  T_VBP = 33;
    localparam int T_HT = T_HV + T_HFP + T_HS + T_HBP;
    localparam int T_FT = T_HT * (T_VV + T_VFP + T_VS + T_VBP);

    localparam logic SYNC_POL = 1'b0;

    localparam logic [11:0] BAR_COLOURS [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] sel_pattern = 2'd0;

    logic       w_hs, w_vs, w_de, w_fs;
    logic [9:0] w_x, w_y;
    logic [3:0] w_r, w_g, w_b;
    logic       t_hs, t_vs, t_de, t_fs;
    logic [9:0] t_x, t_y;
    logic [3:0] t_r, t_g, t_b;

    obs_t obs_w, obs_t_dut;
    obs_t exp_w_q [$];
    obs_t exp_t_q [$];
    int   frame_pat_w [$];
    int   frame_pat_t [$];
    int   edges = 0;
    int   checks = 0;
    int   errors = 0;

    assign obs_w     = {w_de, w_hs, w_vs, w_fs, w_x, w_y, w_r, w_g, w_b};
    assign obs_t_dut = {t_de, t_hs, t_vs, t_fs, t_x, t_y, t_r, t_g, t_b};

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .CLK_DIV(W_DIV), .H_VISIBLE(W_HV), .H_FP(W_HFP), .H_SYNC(W_HS), .H_BP(W_HBP),
        .V_VISIBLE(W_VV), .V_FP(W_VFP), .V_SYNC(W_VS), .V_BP(W_VBP), .SYNC_POL(SYNC_POL)
    ) dut_wide (
        .clk(clk), .reset_n(reset_n), .sel_pattern(sel_pattern),
        .h_sync(w_hs), .v_sync(w_vs), .de(w_de), .x_pixel(w_x), .y_pixel(w_y),
        .frame_start(w_fs), .o_r(w_r), .o_g(w_g), .o_b(w_b)
    );

    vga_pattern_gen #(
        .CLK_DIV(T_DIV), .H_VISIBLE(T_HV), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_VISIBLE(T_VV), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP), .SYNC_POL(SYNC_POL)
    ) dut_tall (
        .clk(clk), .reset_n(reset_n), .sel_pattern(sel_pattern),
        .h_sync(t_hs), .v_sync(t_vs), .de(t_de), .x_pixel(t_x), .y_pixel(t_y),
        .frame_start(t_fs), .o_r(t_r), .o_g(t_g), .o_b(t_b)
    );

    // Expected outputs after the k-th pixel tick (k=0 means none yet): tick k shows raster pixel k-1.
    function automatic obs_t predict(input int k, input int pat, input logic fs,
                                     input int hv, input int hfp, input int hsw, input int hbp,
                                     input int vv, input int vfp, input int vsw, input int vbp);
        obs_t        o;
        int          ht, vt, p, h, v;
        logic [11:0] rgb;
        o    = '0;
        o.hs = ~SYNC_POL;
        o.vs = ~SYNC_POL;
        o.fs = fs;
        rgb  = 12'h000;
        if (k > 0) begin
            ht = hv + hfp + hsw + hbp;
            vt = vv + vfp + vsw + vbp;
            p  = k - 1;
            h  = p % ht;
            v  = (p / ht) % vt;
            if (h >= hv + hfp && h < hv + hfp + hsw) o.hs = SYNC_POL;
            if (v >= vv + vfp && v < vv + vfp + vsw) o.vs = SYNC_POL;
            if (h < hv && v < vv) begin
                o.de = 1'b1;
                o.x  = 10'(h);
                o.y  = 10'(v);
                case (pat)
                    0:       rgb = BAR_COLOURS[h / 80];
                    1:       rgb = ((((h / 32) + (v / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
                    2:       rgb = 12'h111 * 12'(h / 64);
                    default: rgb = (v < 160) ? 12'hF00 : ((v < 320) ? 12'h0F0 : 12'h00F);
                endcase
                {o.r, o.g, o.b} = rgb;
            end
        end
        return o;
    endfunction

    // Compare one observed output bundle against its expectation.
    task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got de=%b hs=%b vs=%b fs=%b x=%0d y=%0d rgb=%h%h%h, expected de=%b hs=%b vs=%b fs=%b x=%0d y=%0d rgb=%h%h%h",
                     name, $time, act.de, act.hs, act.vs, act.fs, act.x, act.y, act.r, act.g, act.b,
                     exp.de, exp.hs, exp.vs, exp.fs, exp.x, exp.y, exp.r, exp.g, exp.b);
        end
    endtask

    // Advance the reference model by one system clock edge and queue both expectations.
    task automatic modelEdge();
        int   k;
        int   pat;
        logic fs;
        if (!reset_n) begin
            edges = 0;
            frame_pat_w.delete();
            frame_pat_w.push_back(0);
            frame_pat_t.delete();
            frame_pat_t.push_back(0);
            exp_w_q.push_back(predict(0, 0, 1'b0, W_HV, W_HFP, W_HS, W_HBP, W_VV, W_VFP, W_VS, W_VBP));
            exp_t_q.push_back(predict(0, 0, 1'b0, T_HV, T_HFP, T_HS, T_HBP, T_VV, T_VFP, T_VS, T_VBP));
        end else begin
            edges++;
            fs = ((edges % W_DIV) == 0) && (((edges / W_DIV) % W_FT) == 0);
            if (fs) frame_pat_w.push_back(int'(sel_pattern));
            k   = edges / W_DIV;
            pat = (k > 0) ? frame_pat_w[(k - 1) / W_FT] : 0;
            exp_w_q.push_back(predict(k, pat, fs, W_HV, W_HFP, W_HS, W_HBP, W_VV, W_VFP, W_VS, W_VBP));
            fs = ((edges % T_DIV) == 0) && (((edges / T_DIV) % T_FT) == 0);
            if (fs) frame_pat_t.push_back(int'(sel_pattern));
            k   = edges / T_DIV;
            pat = (k > 0) ? frame_pat_t[(k - 1) / T_FT] : 0;
            exp_t_q.push_back(predict(k, pat, fs, T_HV, T_HFP, T_HS, T_HBP, T_VV, T_VFP, T_VS, T_VBP));
        end
    endtask

    // Drive one clock cycle of inputs just after the falling edge, then model the rising edge.
    task automatic applyStimulus(input logic rst_val, input logic [1:0] sel_val);
        @(negedge clk);
        #1;
        reset_n     = rst_val;
        sel_pattern = sel_val;
        @(posedge clk);
        modelEdge();
    endtask

    // Pull reset low between clock edges and confirm both instances clear without waiting for a clock.
    task automatic assertResetAsync();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_wide", obs_w,
                    predict(0, 0, 1'b0, W_HV, W_HFP, W_HS, W_HBP, W_VV, W_VFP, W_VS, W_VBP));
        checkOutput("async_reset_tall", obs_t_dut,
                    predict(0, 0, 1'b0, T_HV, T_HFP, T_HS, T_HBP, T_VV, T_VFP, T_VS, T_VBP));
        @(posedge clk);
        modelEdge();
    endtask

    // Scoreboard monitor: every falling edge, compare each instance against its oldest expectation.
    always @(negedge clk) begin
        if (exp_w_q.size() > 0) checkOutput("wide", obs_w, exp_w_q.pop_front());
        if (exp_t_q.size() > 0) checkOutput("tall", obs_t_dut, exp_t_q.pop_front());
    end

    // Stimulus: initial reset, random pattern requests, a mid-line reset, then directed pattern windows.
    initial begin
        int         hold;
        int         guard;
        logic [1:0] sel_v;
        hold  = 0;
        sel_v = 2'd0;
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("initial_reset_wide", obs_w,
                    predict(0, 0, 1'b0, W_HV, W_HFP, W_HS, W_HBP, W_VV, W_VFP, W_VS, W_VBP));
        checkOutput("initial_reset_tall", obs_t_dut,
                    predict(0, 0, 1'b0, T_HV, T_HFP, T_HS, T_HBP, T_VV, T_VFP, T_VS, T_VBP));
        repeat (4) applyStimulus(1'b0, 2'd0);

        $display("[TB] random pattern requests");
        for (int i = 0; i < 25000; i++) begin
            if (hold == 0) begin
                sel_v = 2'($urandom_range(0, 3));
                hold  = $urandom_range(1500, 5000);
            end
            hold--;
            applyStimulus(1'b1, sel_v);
        end

        guard = 0;
        while ((((edges / W_DIV) - 1) % W_HT) != 300 && guard < 2000) begin
            applyStimulus(1'b1, sel_v);
            guard++;
        end

        $display("[TB] asynchronous reset mid-line");
        assertResetAsync();
        applyStimulus(1'b0, 2'd3);
        applyStimulus(1'b0, 2'd3);

        $display("[TB] directed pattern windows");
        for (int i = 0; i < 36000; i++) begin
            if (i < 11999)      sel_v = 2'd2;
            else if (i < 19999) sel_v = 2'd3;
            else                sel_v = 2'd1;
            applyStimulus(1'b1, sel_v);
        end

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel source at the far end of the RGB video path: generates 640x480@60 VGA timing plus a 4-bit-per-channel test pattern.
- Its o_r/o_g/o_b outputs feed the per-channel on/off switch filter, which gates them toward the DAC pins.
- Runs from the 100 MHz system clock with an internal pixel-tick divider.
- Pattern selection changes only at frame boundaries, so no frame ever shows two patterns.

Parameters:
- CLK_DIV, 4: system clocks per pixel (pix_tick period).
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch. H_TOTAL = 800.
- V_VISIBLE, 480: active lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch. V_TOTAL = 525.
- SYNC_POL, 0: asserted level of h_sync/v_sync (0 = active-low).

Ports:
- clk  input  1  system clock, 100 MHz
- reset_n  input  1  asynchronous, active-low reset
- sel_pattern  input  2  requested pattern; sampled at frame wrap
- h_sync  output  1  horizontal sync
- v_sync  output  1  vertical sync
- de  output  1  display enable; 1 inside the visible area
- x_pixel  output  10  column of the pixel currently on o_*
- y_pixel  output  10  row of the pixel currently on o_*
- frame_start  output  1  one-clk pulse at frame wrap
- o_r  output  4  red
- o_g  output  4  green
- o_b  output  4  blue

Behaviour:
- Reset is asynchronous, active-low.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, pattern_q=0, o_r/o_g/o_b=0, de=0, x_pixel=0, y_pixel=0, frame_start=0, h_sync=v_sync=~SYNC_POL (deasserted).
- Divider: div_cnt counts 0..CLK_DIV-1. pix_tick=1 when div_cnt==CLK_DIV-1. First pix_tick occurs CLK_DIV clks after reset release.
- Counters, on pix_tick:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - On h wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
- All outputs are registered.
  - On a pix_tick edge they load values decoded from the pre-increment (h_cnt, v_cnt).
  - Outputs therefore lag the counters by exactly one pixel, and x/y/de/sync/RGB are mutually aligned.
  - Between ticks all outputs hold.
- Decode:
  - de = (h<H_VISIBLE) && (v<V_VISIBLE).
  - h_sync = SYNC_POL when 656<=h<=751, else ~SYNC_POL.
  - v_sync = SYNC_POL when 490<=v<=491, else ~SYNC_POL.
  - x_pixel = h when de, else 0. y_pixel = v when de, else 0.
- Frame wrap: the pix_tick where h==H_TOTAL-1 and v==V_TOTAL-1.
  - pattern_q <= sel_pattern on that edge.
  - frame_start=1 for that single clk only.
  - A sel_pattern change at any other time has no visible effect until the next wrap.
- Patterns, with RGB forced to 0 whenever de=0:
  - 0, colour bars: eight 80-px bars, index b=x/80 (comparator chain, no divider). Order: white, yellow, cyan, green, magenta, red, blue, black. R=F for b in {0,1,4,5}; G=F for b in {0..3}; B=F for even b.
  - 1, checkerboard: 32-px squares. RGB=FFF when x[5]^y[5], else 000.
  - 2, gray ramp: R=G=B=x[9:6], giving values 0..9.
  - 3, tri-band: y<160 gives F00; y<320 gives 0F0; otherwise 00F.
- reset_n asserted mid-frame: every register returns to its reset value immediately, with no wait for a clock edge. After release, timing restarts at h=0, v=0 with pattern 0.
- Constraint: H_TOTAL and V_TOTAL must each be < 1024 (10-bit counters).

Decomposition:
- vga_pkg holds:
  - the timing localparams (H_/V_ totals, sync start/end);
  - typedef enum logic [1:0] pattern_e {PAT_BARS, PAT_CHECK, PAT_RAMP, PAT_BANDS};
  - the 4-bit colour constants.
- Sub-module vga_timing contains the divider, h/v counters, and sync/de decode; it exports pix_tick, h_cnt, v_cnt and frame_wrap.
- The top level adds the pattern register, colour decode and output registers.

Test Plan:
- Reset release, pattern 0 -> first pix_tick at clk 4. h_sync falls at h=656, lasting 96 ticks (384 clks). Line period is 3200 clks.
- Run one full frame -> v_sync low for exactly 2 lines (6400 clks). frame_start pulses once every 1,680,000 clks. de high for 307,200 ticks per frame.
- Pattern 0 -> at x=0 RGB=FFF; x=80 gives FF0; x=400 gives F00; x=560 gives 000. At h=640, RGB=000 and de=0.
- sel_pattern 0->1 mid-frame -> the current frame stays bars. After frame_start: pixel (32,0) is FFF, (32,32) is 000.
- Pattern 2 -> x=63 gives 000, x=64 gives 111, x=639 gives 999. Pattern 3 -> y=159 gives F00, y=160 gives 0F0, y=479 gives 00F.
- reset_n low for 3 clks at h=300, v=200 -> outputs reach reset values asynchronously. After release, x/y restart at 0 and pattern is 0.
